// File: rtl/encoder_8to3_pkg.sv
// Shared widths, defaults and output bundle type for the 8-to-3 encoder.
package encoder_8to3_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned CNT_W = 4;  // holds 0..8 without wrapping

  localparam bit MSB_PRIORITY_DEFAULT = 1'b1;

  // One coherent encode result; kept together so every field comes from one sample.
  typedef struct packed {
    logic [OUT_W-1:0] y;
    logic             valid;
    logic             multi;
    logic [CNT_W-1:0] count;
  } enc_out_t;

endpackage

// File: rtl/encoder_8to3_core.sv
// Purely combinational encode of an 8-bit request vector.
// Ports:
//   a     - request vector, bit i means code i
//   y     - index of the winning set bit (0 when a is zero)
//   valid - any bit set
//   multi - more than one bit set
//   count - population count of a (0..8)
// MSB_PRIORITY selects the winner on multi-hot input: 1 = highest index, 0 = lowest.
module encoder_8to3_core
  import encoder_8to3_pkg::*;
#(
  parameter bit MSB_PRIORITY = MSB_PRIORITY_DEFAULT
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] count
);

  // Scan order decides priority: the last set bit visited wins.
  always_comb begin
    y = '0;
    if (MSB_PRIORITY) begin
      for (int i = 0; i < int'(IN_W); i++) begin
        if (a[i]) y = OUT_W'(i);
      end
    end else begin
      for (int i = int'(IN_W) - 1; i >= 0; i--) begin
        if (a[i]) y = OUT_W'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      count = count + CNT_W'(a[i]);
    end
  end

  assign valid = |a;
  assign multi = (count > CNT_W'(1));

endmodule

// File: rtl/encoder_8to3.sv
// 8-to-3 priority encoder with zero, multi-hot and popcount flags.
// Ports:
//   clk   - rising-edge clock (registered mode only)
//   rst   - asynchronous active-high reset, clears registered outputs
//   en    - capture enable (registered mode only)
//   a     - request vector
//   y     - index of the selected set bit
//   valid - at least one bit set in the sample
//   multi - more than one bit set in the sample
//   count - population count of the sample
// REG_OUT = 1 registers the encode result (latency 1, held while en = 0);
// REG_OUT = 0 passes the combinational result straight through.
module encoder_8to3
  import encoder_8to3_pkg::*;
#(
  parameter bit MSB_PRIORITY = MSB_PRIORITY_DEFAULT,
  parameter bit REG_OUT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] count
);

  enc_out_t enc_d;

  encoder_8to3_core #(
    .MSB_PRIORITY(MSB_PRIORITY)
  ) u_core (
    .a    (a),
    .y    (enc_d.y),
    .valid(enc_d.valid),
    .multi(enc_d.multi),
    .count(enc_d.count)
  );

  if (REG_OUT) begin : g_reg
    enc_out_t enc_q;

    // All fields load together so the outputs always describe one sample of a.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        enc_q <= '0;
      end else if (en) begin
        enc_q <= enc_d;
      end
    end

    assign y     = enc_q.y;
    assign valid = enc_q.valid;
    assign multi = enc_q.multi;
    assign count = enc_q.count;
  end else begin : g_comb
    // Clock, reset and enable have no role in the pass-through build.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};

    assign y     = enc_d.y;
    assign valid = enc_d.valid;
    assign multi = enc_d.multi;
    assign count = enc_d.count;
  end

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed self-checking bench for encoder_8to3: default build (MSB priority,
// registered), an LSB-priority registered build and a combinational build.
module tb_encoder_8to3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;

  logic [2:0] y_m,  y_l,  y_c;
  logic       v_m,  v_l,  v_c;
  logic       m_m,  m_l,  m_c;
  logic [3:0] c_m,  c_l,  c_c;

  int unsigned n_checks;
  int unsigned n_fail;

  encoder_8to3 dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .y    (y_m),
    .valid(v_m),
    .multi(m_m),
    .count(c_m)
  );

  encoder_8to3 #(
    .MSB_PRIORITY(1'b0),
    .REG_OUT     (1'b1)
  ) dut_lsb (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .y    (y_l),
    .valid(v_l),
    .multi(m_l),
    .count(c_l)
  );

  encoder_8to3 #(
    .MSB_PRIORITY(1'b1),
    .REG_OUT     (1'b0)
  ) dut_comb (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .y    (y_c),
    .valid(v_c),
    .multi(m_c),
    .count(c_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {y, valid, multi, count}.
  function automatic logic [8:0] pk(input logic [2:0] y, input logic v, input logic m,
                                    input logic [3:0] c);
    return {y, v, m, c};
  endfunction

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {y,v,m,cnt}=%b_%b_%b_%h, expected %b_%b_%b_%h", tag,
               got[8:6], got[5], got[4], got[3:0], exp[8:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b0;
    a   = 8'h00;

    #12;
    check_val("reset_msb", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    check_val("reset_lsb", {y_l, v_l, m_l, c_l}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    // Combinational build ignores reset.
    a = 8'hA4;
    #1;
    check_val("comb_in_reset", {y_c, v_c, m_c, c_c}, pk(3'd7, 1'b1, 1'b1, 4'd3));
    check_val("reg_in_reset", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    rst = 1'b0;

    // One-hot walk, one capture per cycle.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 8'h01 << i;
      #1;
      check_val($sformatf("comb_onehot%0d", i), {y_c, v_c, m_c, c_c},
                pk(3'(i), 1'b1, 1'b0, 4'd1));
      tick();
      check_val($sformatf("onehot%0d", i), {y_m, v_m, m_m, c_m}, pk(3'(i), 1'b1, 1'b0, 4'd1));
    end

    a = 8'h00;
    tick();
    check_val("zero_msb", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    check_val("zero_comb", {y_c, v_c, m_c, c_c}, pk(3'd0, 1'b0, 1'b0, 4'd0));

    a = 8'b1010_0100;
    #1;
    // Not yet captured: registered output still shows the zero sample.
    check_val("latency_before_edge", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    tick();
    check_val("multi_a4_msb", {y_m, v_m, m_m, c_m}, pk(3'd7, 1'b1, 1'b1, 4'd3));
    check_val("multi_a4_lsb", {y_l, v_l, m_l, c_l}, pk(3'd2, 1'b1, 1'b1, 4'd3));

    a = 8'hFF;
    tick();
    check_val("all_ones_msb", {y_m, v_m, m_m, c_m}, pk(3'd7, 1'b1, 1'b1, 4'd8));
    check_val("all_ones_lsb", {y_l, v_l, m_l, c_l}, pk(3'd0, 1'b1, 1'b1, 4'd8));
    check_val("all_ones_comb", {y_c, v_c, m_c, c_c}, pk(3'd7, 1'b1, 1'b1, 4'd8));

    a = 8'b0001_1000;
    tick();
    check_val("two_hot_msb", {y_m, v_m, m_m, c_m}, pk(3'd4, 1'b1, 1'b1, 4'd2));
    check_val("two_hot_lsb", {y_l, v_l, m_l, c_l}, pk(3'd3, 1'b1, 1'b1, 4'd2));

    // Hold while en = 0.
    a = 8'b0001_0000;
    tick();
    check_val("hold_capture", {y_m, v_m, m_m, c_m}, pk(3'd4, 1'b1, 1'b0, 4'd1));
    en = 1'b0;
    a  = 8'b0000_0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("hold_cycle%0d", k), {y_m, v_m, m_m, c_m}, pk(3'd4, 1'b1, 1'b0, 4'd1));
      check_val($sformatf("comb_en_low%0d", k), {y_c, v_c, m_c, c_c},
                pk(3'd1, 1'b1, 1'b0, 4'd1));
    end
    en = 1'b1;
    tick();
    check_val("hold_release", {y_m, v_m, m_m, c_m}, pk(3'd1, 1'b1, 1'b0, 4'd1));

    // Asynchronous reset mid-cycle.
    a = 8'b0100_0000;
    tick();
    check_val("pre_reset", {y_m, v_m, m_m, c_m}, pk(3'd6, 1'b1, 1'b0, 4'd1));
    #3;
    rst = 1'b1;
    #1;
    check_val("async_reset", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    check_val("async_reset_lsb", {y_l, v_l, m_l, c_l}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    tick();
    check_val("reset_beats_en", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    #3;
    rst = 1'b0;
    a   = 8'b0000_1000;
    #1;
    check_val("after_release_no_edge", {y_m, v_m, m_m, c_m}, pk(3'd0, 1'b0, 1'b0, 4'd0));
    tick();
    check_val("resume_capture", {y_m, v_m, m_m, c_m}, pk(3'd3, 1'b1, 1'b0, 4'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
